ps2_packet_sequencer: RTL and testbench

//  Frames a raw PS/2 mouse byte stream into 3-byte packets and queues them for a consumer.
//  - Sync: byte 1 is the first byte with bit SYNC_BIT set.
//  - An inter-byte timeout abandons partial packets.
//  - Completed packets go into a small FIFO drained by a valid/ready handshake.
//  - Sits between the PS/2 byte receiver and the host-side packet consumer.

---
 rtl/ps2_packet_sequencer_if.sv | 26 ++
 rtl/ps2_packet_sequencer.sv | 135 +++++++++++++
 tb/tb_ps2_packet_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_packet_sequencer_if.sv
// Byte-in / packet-out bus of the PS/2 packet sequencer.
// The master side is the byte receiver plus the packet consumer; the sequencer uses the slave side.
interface ps2_packet_sequencer_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic          in_valid;
   logic [7:0]    in_data;
   logic          pkt_valid;
   logic          pkt_ready;
   logic [23:0]   pkt_data;
   logic [LW-1:0] fifo_level;
   logic [7:0]    drop_count;
   logic          resync;

   modport master (
      output in_valid, in_data, pkt_ready,
      input  pkt_valid, pkt_data, fifo_level, drop_count, resync
   );

   modport slave (
      input  in_valid, in_data, pkt_ready,
      output pkt_valid, pkt_data, fifo_level, drop_count, resync
   );
endinterface

// File: rtl/ps2_packet_sequencer.sv
// Frames a PS/2 mouse byte stream into 3-byte packets.
// Completed packets are queued in a small FIFO that the consumer drains.
module ps2_packet_sequencer #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int FIFO_DEPTH     = 4,
   parameter int SYNC_BIT       = 3
) (
   input logic clk,
   input logic reset,
   ps2_packet_sequencer_if.slave bus
);
   localparam int GW = $clog2(TIMEOUT_CYCLES);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic [1:0] {IDLE, B2, B3} state_t;

   state_t        state;
   logic [GW-1:0] gap;
   logic [7:0]    byte1;
   logic [7:0]    byte2;
   logic          resync_q;

   logic [23:0]   mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] rd_next;
   logic [LW-1:0] level;
   logic [LW-1:0] level_next;
   logic [23:0]   head;
   logic [7:0]    drops;

   logic          push;
   logic          pop;
   logic          full;
   logic          push_ok;
   logic          drop;
   logic [23:0]   push_data;

   assign push      = (state == B3) && bus.in_valid;
   assign push_data = {byte1, byte2, bus.in_data};
   assign full      = (level == LW'(FIFO_DEPTH));
   assign pop       = (level != '0) && bus.pkt_ready;
   assign push_ok   = push && (!full || pop);
   assign drop      = push && full && !pop;
   assign rd_next   = pop ? rd_ptr + PW'(1) : rd_ptr;

   always_comb begin
      level_next = level;
      unique case ({push_ok, pop})
         2'b10:   level_next = level + LW'(1);
         2'b01:   level_next = level - LW'(1);
         default: level_next = level;
      endcase
   end

   // Framing FSM; the gap counter only runs while a packet is partially received.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         gap      <= '0;
         byte1    <= '0;
         byte2    <= '0;
         resync_q <= 1'b0;
      end else begin
         resync_q <= 1'b0;
         unique case (state)
            IDLE: begin
               gap <= '0;
               if (bus.in_valid && bus.in_data[SYNC_BIT]) begin
                  byte1 <= bus.in_data;
                  state <= B2;
               end
            end
            B2, B3: begin
               if (bus.in_valid) begin
                  gap <= '0;
                  if (state == B2) begin
                     byte2 <= bus.in_data;
                     state <= B3;
                  end else begin
                     state <= IDLE;
                  end
               end else if (gap == GW'(TIMEOUT_CYCLES - 1)) begin
                  gap      <= '0;
                  state    <= IDLE;
                  resync_q <= 1'b1;
               end else begin
                  gap <= gap + GW'(1);
               end
            end
            default: begin
               gap   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // The head register looks ahead to the entry that will be at the front after this edge,
   // bypassing the memory when that entry is the one being written right now.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         head   <= '0;
         drops  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         rd_ptr <= rd_next;
         level  <= level_next;
         if (level_next != '0) begin
            head <= (push_ok && (wr_ptr == rd_next)) ? push_data : mem[rd_next];
         end
         if (drop && (drops != 8'hFF)) begin
            drops <= drops + 8'd1;
         end
      end
   end

   assign bus.pkt_valid  = (level != '0);
   assign bus.pkt_data   = head;
   assign bus.fifo_level = level;
   assign bus.drop_count = drops;
   assign bus.resync     = resync_q;
endmodule

// File: tb/tb_ps2_packet_sequencer.sv
// Self-checking bench for ps2_packet_sequencer: directed scenarios plus a randomized run
// compared against a queue-based model of packet framing, timeout and FIFO behaviour.
`timescale 1ns/1ps
module tb_ps2_packet_sequencer;
   localparam int TO    = 16;
   localparam int DEPTH = 4;
   localparam int SB    = 3;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic [7:0]  part[$];
   int          idle_m;
   logic [23:0] exp_q[$];
   int          exp_drop;
   bit          exp_resync;

   ps2_packet_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus();

   ps2_packet_sequencer #(
      .TIMEOUT_CYCLES(TO),
      .FIFO_DEPTH(DEPTH),
      .SYNC_BIT(SB)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic model_clear();
      part.delete();
      exp_q.delete();
      idle_m     = 0;
      exp_drop   = 0;
      exp_resync = 1'b0;
   endtask

   // Reference model: partial packet as a byte list, idle-cycle count since the last byte,
   // queue of delivered packets, and a saturating loss counter.
   task automatic model_step(input bit v, input logic [7:0] d, input bit r);
      bit          pop;
      bit          done;
      logic [23:0] pk;
      pop        = (exp_q.size() != 0) && r;
      done       = 1'b0;
      pk         = '0;
      exp_resync = 1'b0;
      if (v) begin
         idle_m = 0;
         if (part.size() == 0) begin
            if (d[SB]) part.push_back(d);
         end else if (part.size() == 1) begin
            part.push_back(d);
         end else begin
            pk   = {part[0], part[1], d};
            done = 1'b1;
            part.delete();
         end
      end else if (part.size() != 0) begin
         idle_m++;
         if (idle_m == TO) begin
            part.delete();
            idle_m     = 0;
            exp_resync = 1'b1;
         end
      end
      if (pop) void'(exp_q.pop_front());
      if (done) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(pk);
         else if (exp_drop < 255) exp_drop++;
      end
   endtask

   task automatic cycle(input bit v, input logic [7:0] d, input bit r);
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.pkt_ready = r;
      @(posedge clk);
      model_step(v, d, r);
      #1;
   endtask

   task automatic send_pkt(input logic [23:0] p, input bit r);
      cycle(1'b1, p[23:16], r);
      cycle(1'b1, p[15:8], r);
      cycle(1'b1, p[7:0], r);
   endtask

   task automatic do_reset();
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.pkt_ready = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if ({bus.pkt_valid, bus.fifo_level, bus.resync} !== '0) begin
         errors++;
         $display("FAIL reset_flags: got %b/%0d/%b expected 0/0/0", bus.pkt_valid, bus.fifo_level, bus.resync);
      end
      checks++;
      if (bus.pkt_data !== 24'h0) begin
         errors++;
         $display("FAIL reset_data: got %h expected 000000", bus.pkt_data);
      end
      checks++;
      if (bus.drop_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_drop: got %0d expected 0", bus.drop_count);
      end
   endtask

   task automatic test_basic();
      do_reset();
      send_pkt(24'h081234, 1'b0);
      checks++;
      if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== 24'h081234 || bus.fifo_level !== LW'(1)) begin
         errors++;
         $display("FAIL basic_packet: got v=%b d=%h lvl=%0d expected v=1 d=081234 lvl=1", bus.pkt_valid, bus.pkt_data, bus.fifo_level);
      end
      cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (bus.pkt_valid !== 1'b0 || bus.fifo_level !== LW'(0)) begin
         errors++;
         $display("FAIL basic_drain: got v=%b lvl=%0d expected v=0 lvl=0", bus.pkt_valid, bus.fifo_level);
      end
   endtask

   task automatic test_sync();
      logic [7:0] seq [5];
      int pulses;
      seq = '{8'h00, 8'h01, 8'h0C, 8'hAA, 8'h55};
      pulses = 0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, seq[i], 1'b0);
         if (bus.resync === 1'b1) pulses++;
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 8'h00, 1'b0);
         if (bus.resync === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL sync_resync: got %0d pulses expected 0", pulses);
      end
      checks++;
      if (bus.fifo_level !== LW'(1) || bus.pkt_data !== 24'h0CAA55 || bus.drop_count !== 8'd0) begin
         errors++;
         $display("FAIL sync_packet: got lvl=%0d d=%h drop=%0d expected lvl=1 d=0caa55 drop=0", bus.fifo_level, bus.pkt_data, bus.drop_count);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      cycle(1'b1, 8'h08, 1'b0);
      cycle(1'b1, 8'h11, 1'b0);
      for (int i = 0; i < TO; i++) begin
         cycle(1'b0, 8'h00, 1'b0);
         checks++;
         if (bus.resync !== (i == TO - 1)) begin
            errors++;
            $display("FAIL timeout_pulse[%0d]: got %b expected %b", i, bus.resync, (i == TO - 1));
         end
      end
      cycle(1'b0, 8'h00, 1'b0);
      checks++;
      if (bus.resync !== 1'b0 || bus.fifo_level !== LW'(0)) begin
         errors++;
         $display("FAIL timeout_after: got resync=%b lvl=%0d expected 0/0", bus.resync, bus.fifo_level);
      end
      send_pkt(24'h092233, 1'b0);
      checks++;
      if (bus.fifo_level !== LW'(1) || bus.pkt_data !== 24'h092233) begin
         errors++;
         $display("FAIL timeout_recover: got lvl=%0d d=%h expected 1/092233", bus.fifo_level, bus.pkt_data);
      end
      do_reset();
      cycle(1'b1, 8'h08, 1'b0);
      cycle(1'b1, 8'h11, 1'b0);
      for (int i = 0; i < TO - 1; i++) begin
         cycle(1'b0, 8'h00, 1'b0);
         checks++;
         if (bus.resync !== 1'b0) begin
            errors++;
            $display("FAIL late_byte_idle[%0d]: got %b expected 0", i, bus.resync);
         end
      end
      cycle(1'b1, 8'h44, 1'b0);
      checks++;
      if (bus.resync !== 1'b0 || bus.fifo_level !== LW'(1) || bus.pkt_data !== 24'h081144) begin
         errors++;
         $display("FAIL late_byte: got resync=%b lvl=%0d d=%h expected 0/1/081144", bus.resync, bus.fifo_level, bus.pkt_data);
      end
   endtask

   task automatic test_fifo_full();
      logic [23:0] pk [5];
      do_reset();
      for (int i = 0; i < 5; i++) begin
         pk[i] = {8'h08 + 8'(i * 16), 8'(i + 1), ~8'(i)};
         send_pkt(pk[i], 1'b0);
      end
      checks++;
      if (bus.fifo_level !== LW'(4) || bus.drop_count !== 8'd1) begin
         errors++;
         $display("FAIL full_level: got lvl=%0d drop=%0d expected 4/1", bus.fifo_level, bus.drop_count);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== pk[i]) begin
            errors++;
            $display("FAIL full_order[%0d]: got v=%b d=%h expected v=1 d=%h", i, bus.pkt_valid, bus.pkt_data, pk[i]);
         end
         cycle(1'b0, 8'h00, 1'b1);
         checks++;
         if (bus.fifo_level !== LW'(3 - i)) begin
            errors++;
            $display("FAIL full_drain_level[%0d]: got %0d expected %0d", i, bus.fifo_level, 3 - i);
         end
      end
      checks++;
      if (bus.pkt_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_empty: got %b expected 0", bus.pkt_valid);
      end
   endtask

   task automatic test_full_with_pop();
      logic [23:0] pk [5];
      do_reset();
      for (int i = 0; i < 5; i++) pk[i] = {8'h88 + 8'(i), 8'h50 + 8'(i), 8'hC0 + 8'(i)};
      for (int i = 0; i < 4; i++) send_pkt(pk[i], 1'b0);
      cycle(1'b1, pk[4][23:16], 1'b0);
      cycle(1'b1, pk[4][15:8], 1'b0);
      cycle(1'b1, pk[4][7:0], 1'b1);
      checks++;
      if (bus.fifo_level !== LW'(4) || bus.drop_count !== 8'd0 || bus.pkt_data !== pk[1]) begin
         errors++;
         $display("FAIL full_pop: got lvl=%0d drop=%0d d=%h expected 4/0/%h", bus.fifo_level, bus.drop_count, bus.pkt_data, pk[1]);
      end
      for (int i = 1; i < 5; i++) begin
         checks++;
         if (bus.pkt_data !== pk[i]) begin
            errors++;
            $display("FAIL full_pop_order[%0d]: got %h expected %h", i, bus.pkt_data, pk[i]);
         end
         cycle(1'b0, 8'h00, 1'b1);
      end
   endtask

   task automatic test_drop_saturate();
      do_reset();
      for (int i = 0; i < 104; i++) send_pkt({8'hF8, 8'(i), 8'(i + 7)}, 1'b0);
      checks++;
      if (bus.drop_count !== 8'd100) begin
         errors++;
         $display("FAIL drop_100: got %0d expected 100", bus.drop_count);
      end
      for (int i = 0; i < 200; i++) send_pkt({8'h0F, 8'(i), 8'(i + 3)}, 1'b0);
      checks++;
      if (bus.drop_count !== 8'd255 || bus.fifo_level !== LW'(4)) begin
         errors++;
         $display("FAIL drop_saturate: got drop=%0d lvl=%0d expected 255/4", bus.drop_count, bus.fifo_level);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 5; i++) send_pkt({8'h48, 8'(i), 8'h77}, 1'b0);
      cycle(1'b1, 8'h48, 1'b0);
      cycle(1'b1, 8'h01, 1'b1);
      #3 reset = 1'b1;
      #2;
      checks++;
      if ({bus.pkt_valid, bus.fifo_level, bus.resync} !== '0 || bus.pkt_data !== 24'h0 || bus.drop_count !== 8'd0) begin
         errors++;
         $display("FAIL async_reset: got v=%b lvl=%0d rs=%b d=%h drop=%0d expected all 0", bus.pkt_valid, bus.fifo_level, bus.resync, bus.pkt_data, bus.drop_count);
      end
      #2 reset = 1'b0;
      model_clear();
      cycle(1'b1, 8'h3A, 1'b0);
      cycle(1'b1, 8'h01, 1'b0);
      checks++;
      if (bus.pkt_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_no_early_pkt: got %b expected 0", bus.pkt_valid);
      end
      cycle(1'b1, 8'h02, 1'b0);
      checks++;
      if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== 24'h3A0102) begin
         errors++;
         $display("FAIL async_resume: got v=%b d=%h expected 1/3a0102", bus.pkt_valid, bus.pkt_data);
      end
   endtask

   task automatic test_random();
      int          idle_left;
      int          ready_pct;
      bit          v;
      bit          r;
      logic [7:0]  d;
      logic [LW-1:0] el;
      do_reset();
      idle_left = 0;
      ready_pct = 50;
      for (int n = 0; n < 3000; n++) begin
         if (n % 250 == 0) ready_pct = $urandom_range(0, 100);
         if (idle_left > 0) begin
            v = 1'b0;
            idle_left--;
         end else if ($urandom_range(0, 29) == 0) begin
            v = 1'b0;
            idle_left = $urandom_range(10, 20);
         end else begin
            v = ($urandom_range(0, 3) != 0);
         end
         d = 8'($urandom);
         if ($urandom_range(0, 1) == 0) d[SB] = 1'b1;
         r = ($urandom_range(0, 99) < ready_pct);
         cycle(v, d, r);
         el = LW'(exp_q.size());
         checks++;
         if (bus.pkt_valid !== (exp_q.size() != 0) || bus.fifo_level !== el) begin
            errors++;
            $display("FAIL rand_level@%0d: got v=%b lvl=%0d expected lvl=%0d", n, bus.pkt_valid, bus.fifo_level, el);
         end
         checks++;
         if (bus.drop_count !== 8'(exp_drop) || bus.resync !== exp_resync) begin
            errors++;
            $display("FAIL rand_status@%0d: got drop=%0d rs=%b expected drop=%0d rs=%b", n, bus.drop_count, bus.resync, exp_drop, exp_resync);
         end
         if (exp_q.size() != 0) begin
            checks++;
            if (bus.pkt_data !== exp_q[0]) begin
               errors++;
               $display("FAIL rand_data@%0d: got %h expected %h", n, bus.pkt_data, exp_q[0]);
            end
         end
      end
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.pkt_ready = 1'b0;
      model_clear();
      test_reset();
      test_basic();
      test_sync();
      test_timeout();
      test_fifo_full();
      test_full_with_pop();
      test_drop_saturate();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
